// File: rtl/op_n_to_2_pipe.sv
// Pipelined carry-save (Wallace) reduction of OP_NUM operands to a sum/carry pair,
// with a final carry-propagate add and valid/ready flow control.
module op_n_to_2_pipe #(
  parameter int          OP_NUM    = 19,
  parameter int          OP_WIDTH  = 64,
  parameter logic [31:0] PIPE_MASK = 32'h0000_0015,
  parameter int          TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op [OP_NUM],
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_WIDTH-1:0]  out_cs [2],
  output logic [OP_WIDTH-1:0]  out_sum,
  output logic [TAG_WIDTH-1:0] out_tag
);

  function automatic int next_cnt(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int count_stages(input int n);
    int m;
    int s;
    m = n;
    s = 0;
    while (m > 2) begin
      m = next_cnt(m);
      s++;
    end
    return s;
  endfunction

  function automatic int ops_at(input int k);
    int m;
    m = OP_NUM;
    for (int i = 0; i < k; i++) m = next_cnt(m);
    return m;
  endfunction

  localparam int STAGES = (OP_NUM < 3) ? 1 : count_stages(OP_NUM);

  if (OP_NUM < 3 || OP_NUM > 64) begin : g_bad_op_num
    $error("op_n_to_2_pipe: OP_NUM must be within 3..64");
  end

  logic                 out_en;
  logic                 out_valid_q;
  logic [OP_WIDTH-1:0]  out_cs_q [2];
  logic [OP_WIDTH-1:0]  out_sum_q;
  logic [OP_WIDTH-1:0]  out_sum_d;
  logic [TAG_WIDTH-1:0] out_tag_q;

  assign out_en = !out_valid_q || out_ready;

  genvar gk, gi;
  for (gk = 0; gk < STAGES; gk++) begin : g_stage
    localparam int N  = ops_at(gk);
    localparam int G  = N / 3;
    localparam int NO = next_cnt(N);

    logic [OP_WIDTH-1:0]  op_in  [OP_NUM];
    logic [OP_WIDTH-1:0]  csa    [OP_NUM];
    logic [OP_WIDTH-1:0]  op_nxt [OP_NUM];
    logic                 v_in;
    logic                 v_nxt;
    logic [TAG_WIDTH-1:0] tag_in;
    logic [TAG_WIDTH-1:0] tag_nxt;
    logic                 rdy_in;
    logic                 rdy_out;

    if (gk == 0) begin : g_src
      for (gi = 0; gi < OP_NUM; gi++) begin : g_op
        assign op_in[gi] = in_op[gi];
      end
      assign v_in   = in_valid;
      assign tag_in = in_tag;
    end else begin : g_src
      for (gi = 0; gi < OP_NUM; gi++) begin : g_op
        assign op_in[gi] = g_stage[gk-1].op_nxt[gi];
      end
      assign v_in   = g_stage[gk-1].v_nxt;
      assign tag_in = g_stage[gk-1].tag_nxt;
    end

    // Full-adder rows: each triple becomes a sum vector and a left-shifted carry vector.
    for (gi = 0; gi < G; gi++) begin : g_fa
      logic [OP_WIDTH-1:0] a, b, c;
      assign a = op_in[3*gi];
      assign b = op_in[3*gi+1];
      assign c = op_in[3*gi+2];
      assign csa[2*gi]   = a ^ b ^ c;
      assign csa[2*gi+1] = ((a & b) | (a & c) | (b & c)) << 1;
    end
    for (gi = 3 * G; gi < N; gi++) begin : g_pass
      assign csa[2*G + gi - 3*G] = op_in[gi];
    end
    for (gi = NO; gi < OP_NUM; gi++) begin : g_zero
      assign csa[gi] = '0;
    end

    if (gk == STAGES - 1) begin : g_dn
      assign rdy_out = out_en;
    end else begin : g_dn
      assign rdy_out = g_stage[gk+1].rdy_in;
    end

    if (gk < STAGES - 1 && PIPE_MASK[gk]) begin : g_reg
      logic [OP_WIDTH-1:0]  op_q [OP_NUM];
      logic                 valid_q;
      logic [TAG_WIDTH-1:0] tag_q;

      assign rdy_in = !valid_q || rdy_out;

      always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else if (rdy_in) valid_q <= v_in;
      end

      always_ff @(posedge clk) begin
        if (rdy_in) begin
          for (int m = 0; m < OP_NUM; m++) op_q[m] <= csa[m];
          tag_q <= tag_in;
        end
      end

      for (gi = 0; gi < OP_NUM; gi++) begin : g_o
        assign op_nxt[gi] = op_q[gi];
      end
      assign v_nxt   = valid_q;
      assign tag_nxt = tag_q;
    end else begin : g_wire
      assign rdy_in = rdy_out;
      for (gi = 0; gi < OP_NUM; gi++) begin : g_o
        assign op_nxt[gi] = csa[gi];
      end
      assign v_nxt   = v_in;
      assign tag_nxt = tag_in;
    end
  end

  assign in_ready  = g_stage[0].rdy_in;
  assign out_sum_d = g_stage[STAGES-1].op_nxt[0] + g_stage[STAGES-1].op_nxt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_cs_q[0] <= '0;
      out_cs_q[1] <= '0;
      out_sum_q   <= '0;
      out_tag_q   <= '0;
    end else if (out_en) begin
      out_valid_q <= g_stage[STAGES-1].v_nxt;
      out_cs_q[0] <= g_stage[STAGES-1].op_nxt[0];
      out_cs_q[1] <= g_stage[STAGES-1].op_nxt[1];
      out_sum_q   <= out_sum_d;
      out_tag_q   <= g_stage[STAGES-1].tag_nxt;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cs[0] = out_cs_q[0];
  assign out_cs[1] = out_cs_q[1];
  assign out_sum   = out_sum_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_op_n_to_2_pipe.sv
// Directed bench for op_n_to_2_pipe: three elaborations (19 default, 3 unpiped, 64 fully piped).
module tb_op_n_to_2_pipe;

  localparam int LA = 4;   // 19 operands, mask 0x15
  localparam int LB = 1;   // 3 operands, no pipe
  localparam int LC = 10;  // 64 operands, all stages piped

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [63:0] a_in_op [19];
  logic [0:0]  a_in_tag = 1'b0, a_out_tag;
  logic [63:0] a_out_cs [2];
  logic [63:0] a_out_sum;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [63:0] b_in_op [3];
  logic [0:0]  b_in_tag = 1'b0, b_out_tag;
  logic [63:0] b_out_cs [2];
  logic [63:0] b_out_sum;

  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
  logic [63:0] c_in_op [64];
  logic [0:0]  c_in_tag = 1'b0, c_out_tag;
  logic [63:0] c_out_cs [2];
  logic [63:0] c_out_sum;

  op_n_to_2_pipe #(.OP_NUM(19), .OP_WIDTH(64), .PIPE_MASK(32'h0000_0015), .TAG_WIDTH(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
    .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_cs(a_out_cs),
    .out_sum(a_out_sum), .out_tag(a_out_tag));

  op_n_to_2_pipe #(.OP_NUM(3), .OP_WIDTH(64), .PIPE_MASK(32'h0), .TAG_WIDTH(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cs(b_out_cs),
    .out_sum(b_out_sum), .out_tag(b_out_tag));

  op_n_to_2_pipe #(.OP_NUM(64), .OP_WIDTH(64), .PIPE_MASK(32'hFFFF_FFFF), .TAG_WIDTH(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_op(c_in_op),
    .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_cs(c_out_cs),
    .out_sum(c_out_sum), .out_tag(c_out_tag));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] a_ref();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 19; i++) s += a_in_op[i];
    return s;
  endfunction

  function automatic logic [63:0] c_ref();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) s += c_in_op[i];
    return s;
  endfunction

  // Single beat into DUT a with an idle pipe; checks latency, sum, carry-save pair and tag.
  task automatic a_single(input logic [63:0] exp_sum, input logic exp_tag, input string name);
    int n;
    a_out_ready = 1'b1;
    a_in_tag    = exp_tag;
    a_in_valid  = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, a_in_ready);
    end
    tick();
    a_in_valid = 1'b0;
    n = 1;
    while (a_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LA) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, LA);
    end
    checks++;
    if (a_out_sum !== exp_sum) begin
      errors++; $display("FAIL %s_sum: got %h expected %h", name, a_out_sum, exp_sum);
    end
    checks++;
    if (a_out_cs[0] + a_out_cs[1] !== exp_sum) begin
      errors++; $display("FAIL %s_cs: got %h expected %h", name, a_out_cs[0] + a_out_cs[1], exp_sum);
    end
    checks++;
    if (a_out_tag !== exp_tag) begin
      errors++; $display("FAIL %s_tag: got %b expected %b", name, a_out_tag, exp_tag);
    end
    $display("beat %s: lat=%0d sum=%h tag=%b", name, n, a_out_sum, a_out_tag);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b%b%b expected 000", a_out_valid, b_out_valid, c_out_valid);
    end
    checks++;
    if (a_out_sum !== 64'd0 || a_out_cs[0] !== 64'd0 || a_out_cs[1] !== 64'd0 || a_out_tag !== 1'b0) begin
      errors++; $display("FAIL reset_data: got sum=%h tag=%b expected 0", a_out_sum, a_out_tag);
    end
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b%b%b expected 111", a_in_ready, b_in_ready, c_in_ready);
    end
    $display("reset: out_valid=%b in_ready=%b", a_out_valid, a_in_ready);
  endtask

  task automatic test_latency();
    for (int i = 0; i < 19; i++) a_in_op[i] = 64'(i + 1);
    a_single(64'd190, 1'b1, "latency");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 19; i++) a_in_op[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    a_single(64'hFFFF_FFFF_FFFF_FFED, 1'b0, "all_ones");
    for (int i = 0; i < 19; i++) a_in_op[i] = 64'd0;
    a_in_op[0] = 64'h8000_0000_0000_0000;
    a_in_op[1] = 64'h8000_0000_0000_0000;
    a_single(64'd0, 1'b1, "msb_wrap");
  endtask

  task automatic test_stall();
    logic [63:0] exp_q [$];
    logic [0:0]  tag_q [$];
    logic [63:0] held_sum, held_cs0;
    logic [0:0]  held_tag;
    int sent, recv, cyc;
    bit was_stalled, saw_not_ready, accepted;
    sent = 0; recv = 0; cyc = 0;
    was_stalled = 1'b0; saw_not_ready = 1'b0;
    held_sum = '0; held_cs0 = '0; held_tag = '0;
    while (recv < 100 && cyc < 2000) begin
      if (was_stalled) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== held_sum || a_out_cs[0] !== held_cs0 || a_out_tag !== held_tag) begin
          errors++; $display("FAIL stall_hold: got v=%b sum=%h expected v=1 sum=%h", a_out_valid, a_out_sum, held_sum);
        end
      end
      a_out_ready = !(cyc >= 10 && cyc < 20);
      if (!a_in_valid && sent < 100) begin
        for (int i = 0; i < 19; i++) a_in_op[i] = {$urandom(), $urandom()};
        a_in_tag   = 1'($urandom());
        a_in_valid = 1'b1;
      end
      #1;
      if (a_in_valid && !a_in_ready) saw_not_ready = 1'b1;
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got sum=%h expected no beat", a_out_sum);
        end else begin
          if (a_out_sum !== exp_q[0] || a_out_cs[0] + a_out_cs[1] !== exp_q[0] || a_out_tag !== tag_q[0]) begin
            errors++; $display("FAIL stream_beat%0d: got sum=%h tag=%b expected sum=%h tag=%b",
                               recv, a_out_sum, a_out_tag, exp_q[0], tag_q[0]);
          end
          $display("stream beat %0d: sum=%h tag=%b", recv, a_out_sum, a_out_tag);
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        recv++;
      end
      was_stalled = a_out_valid && !a_out_ready;
      held_sum = a_out_sum; held_cs0 = a_out_cs[0]; held_tag = a_out_tag;
      accepted = a_in_valid && a_in_ready;
      if (accepted) begin
        exp_q.push_back(a_ref());
        tag_q.push_back(a_in_tag);
        sent++;
      end
      tick();
      if (accepted) a_in_valid = 1'b0;
      cyc++;
    end
    a_out_ready = 1'b1;
    checks++;
    if (recv !== 100 || sent !== 100) begin
      errors++; $display("FAIL stream_count: got sent=%0d recv=%0d expected 100", sent, recv);
    end
    checks++;
    if (saw_not_ready !== 1'b1) begin
      errors++; $display("FAIL stream_backpressure: got in_ready never low expected low during stall");
    end
    repeat (LA + 2) tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_dup: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q [$];
    int first, got;
    first = -1; got = 0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 20 + LA + 2; c++) begin
      if (c < 20) begin
        for (int i = 0; i < 19; i++) a_in_op[i] = 64'(c * 1000 + i * 7);
        a_in_valid = 1'b1;
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (a_in_valid) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready%0d: got %b expected 1", c, a_in_ready);
        end
        exp_q.push_back(a_ref());
      end
      if (first >= 0 && c < first + 20) begin
        checks++;
        if (a_out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_gap%0d: got out_valid=%b expected 1", c, a_out_valid);
        end
      end
      if (a_out_valid) begin
        if (first < 0) first = c;
        checks++;
        if (exp_q.size() == 0 || a_out_sum !== exp_q[0]) begin
          errors++; $display("FAIL b2b_sum%0d: got %h expected %h", got, a_out_sum, (exp_q.size() == 0) ? 64'd0 : exp_q[0]);
        end
        $display("b2b beat %0d: sum=%h", got, a_out_sum);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    checks++;
    if (first !== LA || got !== 20) begin
      errors++; $display("FAIL b2b_first: got first=%0d count=%0d expected first=%0d count=20", first, got, LA);
    end
  endtask

  task automatic test_reset_flush();
    int seen;
    a_out_ready = 1'b1;
    a_in_tag    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 19; i++) a_in_op[i] = 64'(c + i);
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_sum !== 64'd0 || a_out_tag !== 1'b0) begin
      errors++; $display("FAIL flush_reset: got v=%b sum=%h tag=%b expected 0", a_out_valid, a_out_sum, a_out_tag);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (a_out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_ghost: got %0d beats expected 0", seen);
    end
    $display("flush: ghost beats=%0d", seen);
    for (int i = 0; i < 19; i++) a_in_op[i] = 64'(3 * i);
    a_single(64'd513, 1'b0, "post_reset");
  endtask

  task automatic test_small();
    b_in_op[0] = 64'd5; b_in_op[1] = 64'd7; b_in_op[2] = 64'd9;
    b_in_tag = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++; $display("FAIL small_in_ready: got %b expected 1", b_in_ready);
    end
    tick();
    b_in_valid = 1'b0;
    checks++;
    if (b_out_valid !== 1'b1) begin
      errors++; $display("FAIL small_latency: got out_valid=%b expected 1 after %0d cycle", b_out_valid, LB);
    end
    checks++;
    if (b_out_sum !== 64'd21 || b_out_cs[0] + b_out_cs[1] !== 64'd21 || b_out_tag !== 1'b1) begin
      errors++; $display("FAIL small_sum: got sum=%0d tag=%b expected 21 tag=1", b_out_sum, b_out_tag);
    end
    $display("small beat: sum=%0d tag=%b", b_out_sum, b_out_tag);
    tick();
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++; $display("FAIL small_drain: got out_valid=%b expected 0", b_out_valid);
    end
  endtask

  task automatic test_wide();
    logic [63:0] exp_q [$];
    int first, got;
    first = -1; got = 0;
    c_out_ready = 1'b1;
    for (int c = 0; c < 16 + LC + 2; c++) begin
      if (c < 16) begin
        for (int i = 0; i < 64; i++) c_in_op[i] = {$urandom(), $urandom()};
        c_in_valid = 1'b1;
      end else begin
        c_in_valid = 1'b0;
      end
      #1;
      if (c_in_valid && c_in_ready) exp_q.push_back(c_ref());
      if (c_out_valid) begin
        if (first < 0) first = c;
        checks++;
        if (exp_q.size() == 0 || c_out_sum !== exp_q[0] || c_out_cs[0] + c_out_cs[1] !== c_out_sum) begin
          errors++; $display("FAIL wide_sum%0d: got %h expected %h", got, c_out_sum, (exp_q.size() == 0) ? 64'd0 : exp_q[0]);
        end
        $display("wide beat %0d: sum=%h", got, c_out_sum);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      tick();
    end
    checks++;
    if (first !== LC || got !== 16) begin
      errors++; $display("FAIL wide_latency: got first=%0d count=%0d expected first=%0d count=16", first, got, LC);
    end
  endtask

  initial begin
    for (int i = 0; i < 19; i++) a_in_op[i] = '0;
    for (int i = 0; i < 3; i++)  b_in_op[i] = '0;
    for (int i = 0; i < 64; i++) c_in_op[i] = '0;
    #1;
    test_reset();
    test_latency();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_flush();
    test_small();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
